cdiv_share_arbiter: RTL and testbench
=====================================

Name: cdiv_share_arbiter

Overview:
Round-robin arbiter sharing one pipelined complex_div unit between NUM_REQ requesters, e.g. the diagonal-inverse sweep, back-substitution and normalisation stages of the matrix-inverse engine. Tags every issued operation with its requester index in an in-order tag FIFO and routes each divider result back to the originating requester. Sits between the requester datapaths and the single complex_div instance.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
MAX_INFLIGHT, 4, tag FIFO depth = max ops issued but not yet returned (power of 2)
IDX_W, $clog2(NUM_REQ), requester index width (derived)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  abort all in-flight operations
req_operands_i  in  NUM_REQ x 4 x 64  per-requester {b2,a2,b1,a1}
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester request accepted
resp_result_o  out  2 x 64  result {b,a}, broadcast to all requesters
resp_status_o  out  5  fpnew_pkg::status_t of result, broadcast
resp_valid_o  out  NUM_REQ  one-hot result valid
resp_ready_i  in  NUM_REQ  per-requester result ready
div_operands_o  out  4 x 64  to complex_div operands_i
div_in_valid_o  out  1  to complex_div in_valid_i
div_in_ready_i  in  1  from complex_div in_ready_o
div_result_i  in  2 x 64  from complex_div result_o
div_status_i  in  5  from complex_div status_o
div_out_valid_i  in  1  from complex_div out_valid_o
div_out_ready_o  out  1  to complex_div out_ready_i
div_flush_o  out  1  to complex_div flush_i
busy_o  out  1  any op in flight or lock held
err_o  out  1  sticky: divider returned result with tag FIFO empty

Behaviour:
- Reset (async, rst_ni low): rr_ptr=0, lock_q=0, lock_idx=0, FIFO empty (count=0), err_o=0; hence all req_ready_o=0, resp_valid_o=0, div_in_valid_o=0, div_out_ready_o=0, busy_o=0. Reset mid-operation discards everything; requesters re-issue.
- Grant (combinational): if lock_q, grant=lock_idx; else first i in order rr_ptr, rr_ptr+1, ... (mod NUM_REQ) with req_valid_i[i]=1.
- div_in_valid_o = req_valid_i[grant] & !full & !flush_i. div_operands_o = req_operands_i[grant] (zero when no valid requester).
- req_ready_o[grant] = div_in_ready_i & !full & !flush_i; all other bits 0.
- Issue = div_in_valid_o & div_in_ready_i: push grant into FIFO, rr_ptr <= (grant+1) mod NUM_REQ, lock_q <= 0. Zero added latency: requester operands reach divider same cycle.
- Lock: div_in_valid_o & !div_in_ready_i sets lock_q=1, lock_idx=grant; grant frozen until issue so div_in_valid_o/operands stay stable. Requesters must hold valid until ready.
- Full (count==MAX_INFLIGHT): no issue, even if a pop occurs that cycle. Lock not set while blocked by full.
- Return: head=FIFO head tag. resp_valid_o[head] = div_out_valid_i & !empty; div_out_ready_o = !empty ? resp_ready_i[head] : 1. resp_result_o/resp_status_o = div_result_i/div_status_i combinationally.
- Pop on div_out_valid_i & div_out_ready_o & !empty. Simultaneous push and pop: count unchanged, both pointers advance.
- Empty with div_out_valid_i=1: result consumed and dropped, err_o <= 1 (cleared only by reset).
- Stalled requester at head blocks all returns (in-order); other requesters may still issue until full.
- Flush: div_flush_o = flush_i. Cycle flush_i=1: no issue, no pop, resp_valid_o=0; next edge FIFO emptied, lock_q=0, rr_ptr retained.
- busy_o = !empty | lock_q.

Decomposition:
- Package cdiv_arb_pkg: cdiv_operands_t (4x64), cdiv_result_t (2x64), default NUM_REQ/MAX_INFLIGHT constants; status reuses fpnew_pkg::status_t.
- One sub-module: cdiv_tag_fifo (MAX_INFLIGHT x IDX_W, push/pop/flush, full/empty/count).

Test Plan:
- Single requester: req 1 issues 1+0i / 2+0i, divider model latency 3 -> req_ready_o=0b0010 at issue, resp_valid_o=0b0010 three cycles later with result 0.5+0i.
- All 4 valid continuously, div_in_ready_i=1 -> issue order 0,1,2,3,0,...; results returned one-hot in same order.
- div_in_ready_i low 5 cycles while req 2 granted, req 0 raises valid meanwhile -> grant stays 2, operands stable, req 2 issues first, then req 3 then 0.
- MAX_INFLIGHT=4 issued, resp_ready_i all 0 -> 5th request blocked (req_ready_o=0), busy_o=1; release ready -> drain in order, 5th issues after first pop.
- Head requester resp_ready_i=0 for 4 cycles -> div_out_ready_o=0, no result lost; flush_i pulse with 3 in flight -> div_flush_o=1, next cycle count=0, busy_o=0.
- div_out_valid_i with FIFO empty -> div_out_ready_o=1, no resp_valid_o, err_o=1 sticky until rst_ni.

Source files
------------

// File: rtl/cdiv_arb_pkg.sv
// Shared types and defaults for the complex-divider share arbiter.
// Operands and results travel as packed 64-bit double lanes.
package cdiv_arb_pkg;

    localparam int unsigned DefaultNumReq      = 4;
    localparam int unsigned DefaultMaxInflight = 4;
    localparam int unsigned FpW                = 64;

    typedef struct packed {
        logic [FpW-1:0] b2;
        logic [FpW-1:0] a2;
        logic [FpW-1:0] b1;
        logic [FpW-1:0] a1;
    } cdiv_operands_t;

    typedef struct packed {
        logic [FpW-1:0] b;
        logic [FpW-1:0] a;
    } cdiv_result_t;

    // Same bit layout as fpnew_pkg::status_t, so divider flags pass through untouched.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    localparam int unsigned OperandsW = $bits(cdiv_operands_t);
    localparam int unsigned ResultW   = $bits(cdiv_result_t);
    localparam int unsigned StatusW   = $bits(status_t);

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdiv_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight divider operation.
// Flush empties the FIFO on the next edge and overrides any push or pop.
module cdiv_tag_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cdiv_share_arbiter.sv
// Round-robin arbiter sharing one pipelined complex divider between NUM_REQ requesters.
// Issue order is tagged in a FIFO so in-order results are routed back to their owner.
module cdiv_share_arbiter
    import cdiv_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DefaultNumReq,
    parameter int unsigned MAX_INFLIGHT = DefaultMaxInflight,
    parameter int unsigned IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic [NUM_REQ*OperandsW-1:0]   req_operands_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [ResultW-1:0]             resp_result_o,
    output logic [StatusW-1:0]             resp_status_o,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    input  logic [NUM_REQ-1:0]             resp_ready_i,
    output logic [OperandsW-1:0]           div_operands_o,
    output logic                           div_in_valid_o,
    input  logic                           div_in_ready_i,
    input  logic [ResultW-1:0]             div_result_i,
    input  logic [StatusW-1:0]             div_status_i,
    input  logic                           div_out_valid_i,
    output logic                           div_out_ready_o,
    output logic                           div_flush_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);

    cdiv_operands_t   req_ops [NUM_REQ];
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             lock_q, lock_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] rr_grant, grant, head;
    logic             rr_found, have_req;
    logic             full, empty, issue, pop;
    logic [CntW-1:0]  count;

    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
        assign req_ops[i] = req_operands_i[i*OperandsW +: OperandsW];
    end

    // Scan from rr_ptr upward, wrapping, and take the first valid requester.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        rr_found = 1'b0;
        rr_grant = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand     = (32'(rr_ptr_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!rr_found && req_valid_i[cand_idx]) begin
                rr_found = 1'b1;
                rr_grant = cand_idx;
            end
        end
    end

    assign grant    = lock_q ? lock_idx_q : rr_grant;
    assign have_req = req_valid_i[grant];

    assign div_in_valid_o = have_req & ~full & ~flush_i;
    assign div_operands_o = have_req ? req_ops[grant] : '0;
    assign issue          = div_in_valid_o & div_in_ready_i;

    always_comb begin
        req_ready_o        = '0;
        req_ready_o[grant] = have_req & div_in_ready_i & ~full & ~flush_i;
    end

    // Hold the grant while the divider back-pressures so its inputs stay stable.
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (flush_i) begin
            lock_d = 1'b0;
        end else if (issue) begin
            lock_d   = 1'b0;
            rr_ptr_d = IDX_W'(rr_next(32'(grant), NUM_REQ));
        end else if (div_in_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = grant;
        end
    end

    always_comb begin
        resp_valid_o       = '0;
        resp_valid_o[head] = div_out_valid_i & ~empty & ~flush_i;
    end

    // With no owner the result is drained (and flagged) rather than left to wedge the divider.
    assign div_out_ready_o = rst_ni & (empty | resp_ready_i[head]);
    assign pop             = div_out_valid_i & div_out_ready_o & ~empty & ~flush_i;
    assign err_d           = err_q | (div_out_valid_i & empty);

    assign resp_result_o = div_result_i;
    assign resp_status_o = div_status_i;
    assign div_flush_o   = flush_i;
    assign busy_o        = (count != '0) | lock_q;
    assign err_o         = err_q;

    cdiv_tag_fifo #(
        .Depth (MAX_INFLIGHT),
        .Width (IDX_W),
        .CntW  (CntW)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (issue),
        .data_i  (grant),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_cdiv_share_arbiter.sv
// Directed bench for cdiv_share_arbiter; the bench itself plays the complex divider.
// Inputs change just after the falling edge and outputs are checked 1ns later.
module tb_cdiv_share_arbiter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [1023:0] req_ops;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [127:0]  resp_result;
    logic [4:0]    resp_status;
    logic [3:0]    resp_valid;
    logic [3:0]    resp_ready;
    logic [255:0]  div_ops;
    logic          div_in_valid;
    logic          div_in_ready;
    logic [127:0]  div_result;
    logic [4:0]    div_status;
    logic          div_out_valid;
    logic          div_out_ready;
    logic          div_flush;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] D_ONE  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D_TWO  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] D_HALF = 64'h3FE0_0000_0000_0000;

    always #5 clk = ~clk;

    cdiv_share_arbiter #(
        .NUM_REQ      (4),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .req_operands_i  (req_ops),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .resp_result_o   (resp_result),
        .resp_status_o   (resp_status),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .div_operands_o  (div_ops),
        .div_in_valid_o  (div_in_valid),
        .div_in_ready_i  (div_in_ready),
        .div_result_i    (div_result),
        .div_status_i    (div_status),
        .div_out_valid_i (div_out_valid),
        .div_out_ready_o (div_out_ready),
        .div_flush_o     (div_flush),
        .busy_o          (busy),
        .err_o           (err)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns just after the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        flush         = 1'b0;
        req_valid     = '0;
        resp_ready    = '0;
        div_in_ready  = 1'b0;
        div_out_valid = 1'b0;
        div_result    = '0;
        div_status    = '0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [255:0] lane_ops(input int k);
        logic [63:0] v;
        v = 64'h100 + 64'(k);
        return {v, v, v, v};
    endfunction

    initial begin
        req_ops = '0;

        // Reset state
        rst_n = 1'b0;
        flush = 1'b0; req_valid = '0; resp_ready = '0; div_in_ready = 1'b0;
        div_out_valid = 1'b0; div_result = '0; div_status = '0;
        #1;
        chk("rst_req_ready", 256'(req_ready), 256'(4'b0000));
        chk("rst_resp_valid", 256'(resp_valid), 256'(4'b0000));
        chk("rst_div_in_valid", 256'(div_in_valid), 256'(1'b0));
        chk("rst_div_out_ready", 256'(div_out_ready), 256'(1'b0));
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_err", 256'(err), 256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester: (1+0i)/(2+0i) = 0.5+0i, divider latency 3
        req_ops[1*256 +: 256] = {64'h0, D_TWO, 64'h0, D_ONE};
        req_valid = 4'b0010; div_in_ready = 1'b1; resp_ready = 4'b1111;
        #1;
        chk("t1_req_ready", 256'(req_ready), 256'(4'b0010));
        chk("t1_div_in_valid", 256'(div_in_valid), 256'(1'b1));
        chk("t1_div_ops", div_ops, {64'h0, D_TWO, 64'h0, D_ONE});
        tick();
        req_valid = '0;
        #1;
        chk("t1_busy", 256'(busy), 256'(1'b1));
        chk("t1_req_ready_idle", 256'(req_ready), 256'(4'b0000));
        tick();
        tick();
        div_out_valid = 1'b1; div_result = {64'h0, D_HALF}; div_status = 5'b00001;
        #1;
        chk("t1_resp_valid", 256'(resp_valid), 256'(4'b0010));
        chk("t1_resp_result", 256'(resp_result), 256'({64'h0, D_HALF}));
        chk("t1_resp_status", 256'(resp_status), 256'(5'b00001));
        chk("t1_div_out_ready", 256'(div_out_ready), 256'(1'b1));
        tick();
        div_out_valid = 1'b0;
        #1;
        chk("t1_busy_done", 256'(busy), 256'(1'b0));
        chk("t1_resp_idle", 256'(resp_valid), 256'(4'b0000));

        // All four valid: issue 0,1,2,3, then full blocks the fifth
        do_reset();
        for (int k = 0; k < 4; k++) req_ops[k*256 +: 256] = lane_ops(k);
        req_valid = 4'b1111; div_in_ready = 1'b1; resp_ready = 4'b0000;
        #1;
        chk("t2_grant0", 256'(req_ready), 256'(4'b0001));
        chk("t2_ops0", div_ops, lane_ops(0));
        tick(); #1;
        chk("t2_grant1", 256'(req_ready), 256'(4'b0010));
        chk("t2_ops1", div_ops, lane_ops(1));
        tick(); #1;
        chk("t2_grant2", 256'(req_ready), 256'(4'b0100));
        tick(); #1;
        chk("t2_grant3", 256'(req_ready), 256'(4'b1000));
        tick(); #1;
        chk("t2_full_ready", 256'(req_ready), 256'(4'b0000));
        chk("t2_full_in_valid", 256'(div_in_valid), 256'(1'b0));
        chk("t2_full_busy", 256'(busy), 256'(1'b1));
        div_out_valid = 1'b1;
        #1;
        chk("t2_stall_resp", 256'(resp_valid), 256'(4'b0001));
        chk("t2_stall_out_ready", 256'(div_out_ready), 256'(1'b0));
        tick(); #1;
        chk("t2_held_resp", 256'(resp_valid), 256'(4'b0001));
        resp_ready = 4'b1111;
        #1;
        chk("t2_pop_out_ready", 256'(div_out_ready), 256'(1'b1));
        chk("t2_no_issue_on_pop", 256'(req_ready), 256'(4'b0000));
        tick(); #1;
        chk("t2_resp1", 256'(resp_valid), 256'(4'b0010));
        chk("t2_fifth_issue", 256'(req_ready), 256'(4'b0001));
        tick();
        req_valid = '0;
        #1;
        chk("t2_resp2", 256'(resp_valid), 256'(4'b0100));
        tick(); #1;
        chk("t2_resp3", 256'(resp_valid), 256'(4'b1000));
        tick(); #1;
        chk("t2_resp0b", 256'(resp_valid), 256'(4'b0001));
        tick();
        div_out_valid = 1'b0;
        #1;
        chk("t2_drained", 256'(busy), 256'(1'b0));

        // Lock: req 2 granted while divider stalls; req 0 arrives meanwhile
        do_reset();
        for (int k = 0; k < 4; k++) req_ops[k*256 +: 256] = lane_ops(k);
        req_valid = 4'b0100; div_in_ready = 1'b0; resp_ready = 4'b1111;
        #1;
        chk("t3_in_valid", 256'(div_in_valid), 256'(1'b1));
        chk("t3_not_ready", 256'(req_ready), 256'(4'b0000));
        tick();
        req_valid = 4'b0101;
        #1;
        chk("t3_lock_busy", 256'(busy), 256'(1'b1));
        for (int c = 0; c < 4; c++) begin
            chk("t3_ops_stable", div_ops, lane_ops(2));
            tick(); #1;
        end
        div_in_ready = 1'b1;
        #1;
        chk("t3_issue2", 256'(req_ready), 256'(4'b0100));
        tick();
        req_valid = 4'b1001;
        #1;
        chk("t3_issue3", 256'(req_ready), 256'(4'b1000));
        tick(); #1;
        chk("t3_issue0", 256'(req_ready), 256'(4'b0001));
        tick();
        req_valid = '0;

        // Head (req 2) not ready with 3 in flight, then flush
        div_out_valid = 1'b1; resp_ready = 4'b1011;
        #1;
        chk("t4_head_resp", 256'(resp_valid), 256'(4'b0100));
        for (int c = 0; c < 4; c++) begin
            chk("t4_out_ready_low", 256'(div_out_ready), 256'(1'b0));
            tick(); #1;
        end
        chk("t4_head_kept", 256'(resp_valid), 256'(4'b0100));
        flush = 1'b1; req_valid = 4'b0010;
        #1;
        chk("t4_div_flush", 256'(div_flush), 256'(1'b1));
        chk("t4_flush_resp", 256'(resp_valid), 256'(4'b0000));
        chk("t4_flush_no_issue", 256'(req_ready), 256'(4'b0000));
        chk("t4_flush_in_valid", 256'(div_in_valid), 256'(1'b0));
        tick();
        flush = 1'b0; div_out_valid = 1'b0;
        #1;
        chk("t4_busy_cleared", 256'(busy), 256'(1'b0));
        chk("t4_rr_retained", 256'(req_ready), 256'(4'b0010));
        req_valid = '0;

        // Result with empty FIFO: drained, err sticky until reset
        do_reset();
        div_out_valid = 1'b1;
        #1;
        chk("t5_out_ready", 256'(div_out_ready), 256'(1'b1));
        chk("t5_no_resp", 256'(resp_valid), 256'(4'b0000));
        chk("t5_err_pre", 256'(err), 256'(1'b0));
        tick();
        div_out_valid = 1'b0;
        #1;
        chk("t5_err_set", 256'(err), 256'(1'b1));
        tick(); tick(); tick(); #1;
        chk("t5_err_sticky", 256'(err), 256'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("t5_err_reset", 256'(err), 256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
